regfile_access_ctrl: RTL and testbench
======================================

// Module: regfile_access_ctrl
// PURPOSE
//  Initiator side of the register-file port: sequences operand reads (RF_LD=0) and writebacks (RF_LD=1).
//  Sits between decode (issue), execute (operands) and writeback stages of the RISC-V core.
//  Keeps a busy scoreboard so reads never see stale data, and hardwires x0 to zero.
// PARAMETERS
//  DATA_W    32   register data width
//  ADDR_W    5    register address width (2**ADDR_W scoreboard entries)
//  ZERO_REG  1    1: x0 reads as 0, writes to x0 are dropped
// PORTS
//  CLK         in   1       rising-edge clock; single clock domain
//  RST_N       in   1       reset, asynchronous, active-low
//  ISS_VALID   in   1       decode offers instruction
//  ISS_READY   out  1       issue accepted on VALID&READY edge
//  ISS_RS1/RS2 in   ADDR_W  source registers
//  ISS_RD      in   ADDR_W  destination register
//  ISS_RD_WE   in   1       instruction will write back ISS_RD
//  OPR_VALID   out  1       operands valid
//  OPR_READY   in   1       execute accepts operands
//  OPR_A/OPR_B out  DATA_W  operand values
//  OPR_RD      out  ADDR_W  latched ISS_RD
//  OPR_RD_WE   out  1       latched ISS_RD_WE
//  WB_VALID    in   1       writeback request
//  WB_READY    out  1       writeback accepted on VALID&READY edge
//  WB_RD       in   ADDR_W  writeback register
//  WB_DATA     in   DATA_W  writeback value
//  RF_LD       out  1       to register file LD
//  RF_SA/RF_SB out  ADDR_W  to register file SA/SB
//  RF_DR       out  ADDR_W  to register file DR
//  RF_D_IN     out  DATA_W  to register file D_IN
//  RF_DATA_A/B in   DATA_W  from register file; valid 1 cycle after an LD=0 edge
// BEHAVIOUR
//  Reset (RST_N low, async): state IDLE, busy[] all 0, every output 0 (incl. OPR_*, RF_*).
//  FSM IDLE -> RD_ADDR -> RD_CAPT -> HOLD -> IDLE.
//  IDLE: if WB_VALID: WB_READY=1, ISS_READY=0, RF_LD=1 with RF_DR=WB_RD, RF_D_IN=WB_DATA (writeback wins).
//    else ISS_READY=1 iff neither RS1 nor RS2 busy (x0 never busy); on accept latch RS1/RS2/RD/RD_WE -> RD_ADDR.
//  RD_ADDR: RF_LD=0, RF_SA/RF_SB = latched RS1/RS2; WB_READY=0, ISS_READY=0 -> RD_CAPT.
//  RD_CAPT: capture RF_DATA_A/B into OPR_A/B at edge (0 if address is x0 and ZERO_REG) -> HOLD.
//    Writeback allowed here (LD=1 after capture does not corrupt captured data).
//  HOLD: OPR_VALID=1, OPR_* stable; writeback allowed; on OPR_VALID&OPR_READY -> IDLE, OPR_VALID=0 next cycle,
//    and busy[OPR_RD] set if OPR_RD_WE and OPR_RD!=0.
//  Latency: issue-accept edge E0 -> OPR_VALID high after edge E2 (3rd cycle); one instruction in flight.
//  Writeback: accepted in IDLE/RD_CAPT/HOLD; clears busy[WB_RD] at accept edge.
//    WB_RD=0 with ZERO_REG: accepted, RF_LD stays 0 (dropped).
//    Write to a non-busy register: still performed.
//  Any cycle with no accepted writeback and not RD_ADDR: RF_LD=0, RF_SA/SB hold last value.
//  Busy clear in same cycle as a stalled issue: ISS_READY re-evaluated next cycle (no bypass).
//  Set and clear of same busy bit on one edge: set wins (new producer outstanding).
//  Reset mid-operation: in-flight operands discarded, scoreboard cleared; no RF_LD pulse during reset.
// STRUCTURE
//  riscv_pkg: DATA_W/ADDR_W defaults, FSM state encoding (IDLE, RD_ADDR, RD_CAPT, HOLD), REG_ZERO const.
//  Sub-module reg_scoreboard: 2**ADDR_W busy bits, set/clear ports, two combinational lookup ports.
//  Top: FSM, issue/operand latches, RF port mux, x0 masking.
// TESTING
//  1 Reset: RST_N low mid-HOLD -> all outputs 0 immediately, busy cleared, IDLE after release.
//  2 WB x5=0xDEADBEEF then issue RS1=5,RS2=0 -> RF_LD pulse DR=5; OPR_A=0xDEADBEEF, OPR_B=0, VALID on 3rd cycle.
//  3 Issue RD=7,WE=1, consume; issue RS1=7 -> ISS_READY=0 until WB x7=0x12345678 accepted; then OPR_A=0x12345678.
//  4 WB_VALID and ISS_VALID same IDLE cycle -> WB accepted first, issue accepted next cycle.
//  5 WB_VALID during RD_ADDR -> WB_READY=0, RF_LD=0; accepted in RD_CAPT, OPR_A/B unaffected.
//  6 WB x0=0xFFFFFFFF -> WB_READY=1, RF_LD stays 0; later read of x0 yields OPR_A=0; OPR_READY=0 holds OPR stable.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions: default widths, register-file
// access sequencer states and the hardwired-zero register.
package riscv_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_CAPT = 2'd2,
    HOLD    = 2'd3
  } state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy bit per architectural register with one set port,
// one clear port and two combinational lookup ports.
module reg_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_idx_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_idx_i,
  input  logic [ADDR_W-1:0] rd_a_idx_i,
  input  logic [ADDR_W-1:0] rd_b_idx_i,
  output logic              busy_a_o,
  output logic              busy_b_o
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q, busy_d;

  // Clear first so a same-edge set marks the new producer
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_idx_i] = 1'b0;
    if (set_i) busy_d[set_idx_i] = 1'b1;
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  // Busy bit storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_a_o = busy_q[rd_a_idx_i];
  assign busy_b_o = busy_q[rd_b_idx_i];

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file initiator: sequences operand reads and
// writebacks, with a busy scoreboard and x0 hardwired to zero.
module regfile_access_ctrl
  import riscv_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ISS_VALID,
  output logic              ISS_READY,
  input  logic [ADDR_W-1:0] ISS_RS1,
  input  logic [ADDR_W-1:0] ISS_RS2,
  input  logic [ADDR_W-1:0] ISS_RD,
  input  logic              ISS_RD_WE,
  output logic              OPR_VALID,
  input  logic              OPR_READY,
  output logic [DATA_W-1:0] OPR_A,
  output logic [DATA_W-1:0] OPR_B,
  output logic [ADDR_W-1:0] OPR_RD,
  output logic              OPR_RD_WE,
  input  logic              WB_VALID,
  output logic              WB_READY,
  input  logic [ADDR_W-1:0] WB_RD,
  input  logic [DATA_W-1:0] WB_DATA,
  output logic              RF_LD,
  output logic [ADDR_W-1:0] RF_SA,
  output logic [ADDR_W-1:0] RF_SB,
  output logic [ADDR_W-1:0] RF_DR,
  output logic [DATA_W-1:0] RF_D_IN,
  input  logic [DATA_W-1:0] RF_DATA_A,
  input  logic [DATA_W-1:0] RF_DATA_B
);

  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(REG_ZERO);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
  logic              we_q;
  logic [DATA_W-1:0] opa_q, opb_q;

  logic busy_a, busy_b;
  logic iss_rdy, wb_rdy;
  logic iss_acc, wb_acc, opr_acc;
  logic rf_we, sb_set;

  // Handshakes are gated by reset so nothing leaks while held
  assign wb_rdy  = RST_N && (state_q != RD_ADDR);
  assign iss_rdy = RST_N && (state_q == IDLE) &&
                   !WB_VALID && !busy_a && !busy_b;

  assign iss_acc = ISS_VALID && iss_rdy;
  assign wb_acc  = WB_VALID && wb_rdy;
  assign opr_acc = (state_q == HOLD) && OPR_READY;

  assign rf_we  = wb_acc && !(ZERO_REG && (WB_RD == X0));
  assign sb_set = opr_acc && we_q && (rd_q != X0);

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .set_i      (sb_set),
    .set_idx_i  (rd_q),
    .clr_i      (wb_acc),
    .clr_idx_i  (WB_RD),
    .rd_a_idx_i (ISS_RS1),
    .rd_b_idx_i (ISS_RS2),
    .busy_a_o   (busy_a),
    .busy_b_o   (busy_b)
  );

  // Next-state sequencing: one instruction in flight
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (iss_acc) state_d = RD_ADDR;
      RD_ADDR: state_d = RD_CAPT;
      RD_CAPT: state_d = HOLD;
      HOLD:    if (opr_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Latch the accepted issue bundle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
      we_q  <= 1'b0;
    end else if (iss_acc) begin
      rs1_q <= ISS_RS1;
      rs2_q <= ISS_RS2;
      rd_q  <= ISS_RD;
      we_q  <= ISS_RD_WE;
    end
  end

  // Capture read data once, masking x0 to zero
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (state_q == RD_CAPT) begin
      opa_q <= (ZERO_REG && rs1_q == X0) ? '0 : RF_DATA_A;
      opb_q <= (ZERO_REG && rs2_q == X0) ? '0 : RF_DATA_B;
    end
  end

  assign ISS_READY = iss_rdy;
  assign WB_READY  = wb_rdy;
  assign OPR_VALID = (state_q == HOLD);
  assign OPR_A     = opa_q;
  assign OPR_B     = opb_q;
  assign OPR_RD    = rd_q;
  assign OPR_RD_WE = we_q;

  // Read addresses follow the latch, so they hold otherwise
  assign RF_SA   = rs1_q;
  assign RF_SB   = rs2_q;
  assign RF_LD   = rf_we;
  assign RF_DR   = rf_we ? WB_RD : '0;
  assign RF_D_IN = rf_we ? WB_DATA : '0;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with a
// behavioural register file behind the RF port.
module tb_regfile_access_ctrl;

  logic        CLK, RST_N;
  logic        ISS_VALID, ISS_READY;
  logic [4:0]  ISS_RS1, ISS_RS2, ISS_RD;
  logic        ISS_RD_WE;
  logic        OPR_VALID, OPR_READY;
  logic [31:0] OPR_A, OPR_B;
  logic [4:0]  OPR_RD;
  logic        OPR_RD_WE;
  logic        WB_VALID, WB_READY;
  logic [4:0]  WB_RD;
  logic [31:0] WB_DATA;
  logic        RF_LD;
  logic [4:0]  RF_SA, RF_SB, RF_DR;
  logic [31:0] RF_D_IN, RF_DATA_A, RF_DATA_B;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] rf[32];
  logic [31:0] ref_m[32];
  int          errors = 0;
  int          checks = 0;
  int          w;

  regfile_access_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .ISS_VALID(ISS_VALID), .ISS_READY(ISS_READY),
    .ISS_RS1(ISS_RS1), .ISS_RS2(ISS_RS2),
    .ISS_RD(ISS_RD), .ISS_RD_WE(ISS_RD_WE),
    .OPR_VALID(OPR_VALID), .OPR_READY(OPR_READY),
    .OPR_A(OPR_A), .OPR_B(OPR_B),
    .OPR_RD(OPR_RD), .OPR_RD_WE(OPR_RD_WE),
    .WB_VALID(WB_VALID), .WB_READY(WB_READY),
    .WB_RD(WB_RD), .WB_DATA(WB_DATA),
    .RF_LD(RF_LD), .RF_SA(RF_SA), .RF_SB(RF_SB),
    .RF_DR(RF_DR), .RF_D_IN(RF_D_IN),
    .RF_DATA_A(RF_DATA_A), .RF_DATA_B(RF_DATA_B)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file: write on LD, registered read otherwise
  always @(posedge CLK) begin
    if (RF_LD) rf[RF_DR] <= RF_D_IN;
    else begin
      RF_DATA_A <= rf[RF_SA];
      RF_DATA_B <= rf[RF_SB];
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic wb(input logic [4:0] r,
                    input logic [31:0] d);
    int n;
    n = 0;
    WB_VALID = 1'b1; WB_RD = r; WB_DATA = d;
    #1;
    while (!WB_READY && n < 8) begin
      @(negedge CLK); #1; n++;
    end
    if (!WB_READY) chk("wb_timeout", 0, 1);
    else begin
      chk("wb_ld", RF_LD, r != 0);
      if (ISS_VALID) chk("wb_blocks_iss", ISS_READY, 0);
      if (r != 0) begin
        chk("wb_dr", RF_DR, r);
        chk("wb_din", RF_D_IN, d);
        ref_m[r] = d;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    WB_VALID = 1'b0;
  endtask

  task automatic issue(input logic [4:0] a,
                       input logic [4:0] b,
                       input logic [4:0] d,
                       input logic we,
                       output int waits);
    exp_t e;
    ISS_VALID = 1'b1; ISS_RS1 = a; ISS_RS2 = b;
    ISS_RD = d; ISS_RD_WE = we;
    waits = 0;
    #1;
    while (!ISS_READY && waits < 8) begin
      @(negedge CLK); #1; waits++;
    end
    if (!ISS_READY) begin
      chk("iss_timeout", 0, 1);
      ISS_VALID = 1'b0;
    end else begin
      e.a  = (a == 0) ? 32'h0 : ref_m[a];
      e.b  = (b == 0) ? 32'h0 : ref_m[b];
      e.rd = d;
      e.we = we;
      expq.push_back(e);
      @(posedge CLK);
      @(negedge CLK);
      ISS_VALID = 1'b0;
    end
  endtask

  task automatic consume(input int lat0, input int hold);
    int   lat;
    exp_t e;
    lat = lat0;
    while (!OPR_VALID && lat < 8) begin
      @(negedge CLK); lat++;
    end
    chk("opr_latency", lat, 3);
    if (expq.size() == 0) chk("sb_empty", 0, 1);
    else if (OPR_VALID) begin
      e = expq.pop_front();
      chk("opr_a", OPR_A, e.a);
      chk("opr_b", OPR_B, e.b);
      chk("opr_rd", OPR_RD, e.rd);
      chk("opr_we", OPR_RD_WE, e.we);
      for (int i = 0; i < hold; i++) begin
        @(negedge CLK);
        chk("hold_valid", OPR_VALID, 1);
        chk("hold_a", OPR_A, e.a);
        chk("hold_b", OPR_B, e.b);
      end
      OPR_READY = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      OPR_READY = 1'b0;
      chk("valid_drop", OPR_VALID, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i]    = 32'hA5A5A5A5 ^ (i * 32'h01010101);
      ref_m[i] = rf[i];
    end
    RST_N = 1'b0;
    ISS_VALID = 0; ISS_RS1 = 0; ISS_RS2 = 0;
    ISS_RD = 0; ISS_RD_WE = 0; OPR_READY = 0;
    WB_VALID = 1'b1; WB_RD = 5'd3; WB_DATA = 32'h1;
    #1;
    chk("rst_wb_ready", WB_READY, 0);
    chk("rst_rf_ld", RF_LD, 0);
    chk("rst_opr_valid", OPR_VALID, 0);
    chk("rst_iss_ready", ISS_READY, 0);
    chk("rst_rf_sa", RF_SA, 0);
    WB_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // writeback then read it back with x0 alongside
    wb(5'd5, 32'hDEADBEEF);
    issue(5'd5, 5'd0, 5'd1, 1'b0, w);
    chk("iss_idle_wait", w, 0);
    consume(1, 0);

    // producer marks x7 busy; consumer stalls until WB
    issue(5'd0, 5'd0, 5'd7, 1'b1, w);
    consume(1, 0);
    ISS_VALID = 1'b1; ISS_RS1 = 5'd0; ISS_RS2 = 5'd7;
    ISS_RD = 5'd0; ISS_RD_WE = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_rs2", ISS_READY, 0);
      @(negedge CLK); #1;
    end
    ISS_RS1 = 5'd7; ISS_RS2 = 5'd0;
    #1;
    chk("stall_rs1", ISS_READY, 0);
    wb(5'd7, 32'h12345678);
    issue(5'd7, 5'd0, 5'd0, 1'b0, w);
    chk("iss_after_clear", w, 0);
    consume(1, 0);

    // writeback wins over a same-cycle issue
    ISS_VALID = 1'b1; ISS_RS1 = 5'd5; ISS_RS2 = 5'd6;
    wb(5'd6, 32'h0BADF00D);
    issue(5'd5, 5'd6, 5'd2, 1'b1, w);
    chk("iss_next_cycle", w, 0);
    consume(1, 0);
    wb(5'd2, 32'h22222222);

    // writeback during RD_ADDR waits; hits the source reg
    issue(5'd6, 5'd5, 5'd0, 1'b0, w);
    WB_VALID = 1'b1; WB_RD = 5'd6; WB_DATA = 32'hCAFEF00D;
    #1;
    chk("rdaddr_wb_ready", WB_READY, 0);
    chk("rdaddr_rf_ld", RF_LD, 0);
    @(negedge CLK); #1;
    chk("rdcapt_wb_ready", WB_READY, 1);
    chk("rdcapt_rf_ld", RF_LD, 1);
    ref_m[6] = 32'hCAFEF00D;
    @(posedge CLK);
    @(negedge CLK);
    WB_VALID = 1'b0;
    consume(3, 0);
    issue(5'd6, 5'd0, 5'd0, 1'b0, w);
    consume(1, 0);

    // x0 write dropped; x0 read masked; stall holds output
    wb(5'd0, 32'hFFFFFFFF);
    issue(5'd0, 5'd5, 5'd4, 1'b1, w);
    consume(1, 3);

    // reset mid-HOLD discards work and clears busy
    issue(5'd0, 5'd0, 5'd9, 1'b1, w);
    consume(1, 0);
    issue(5'd5, 5'd6, 5'd3, 1'b1, w);
    repeat (2) @(negedge CLK);
    chk("pre_rst_hold", OPR_VALID, 1);
    WB_VALID = 1'b1; WB_RD = 5'd11; WB_DATA = 32'h5;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_valid", OPR_VALID, 0);
    chk("mid_rst_a", OPR_A, 0);
    chk("mid_rst_b", OPR_B, 0);
    chk("mid_rst_rd", {OPR_RD, OPR_RD_WE}, 0);
    chk("mid_rst_rf_ld", RF_LD, 0);
    chk("mid_rst_wb_ready", WB_READY, 0);
    chk("mid_rst_sa", {RF_SA, RF_SB}, 0);
    WB_VALID = 1'b0;
    expq.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    issue(5'd9, 5'd0, 5'd0, 1'b0, w);
    chk("busy_cleared", w, 0);
    consume(1, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
